// File: rtl/c432_key_pkg.sv
// -----------------------------------------------------------------------------
// c432_key_pkg
// Shared types and constants for the c432 key-load controller.
//   - state_e        : controller FSM states
//   - CORE_OUT_W     : width of the locked core's output bundle
//   - *_DEF          : parameter defaults for KEY_W, SETTLE_CYC, MAX_TRIES
//   - cnt_w()        : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package c432_key_pkg;

    localparam int CORE_OUT_W     = 7;
    localparam int KEY_W_DEF      = 4;
    localparam int SETTLE_CYC_DEF = 3;
    localparam int MAX_TRIES_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_LOCKED = 3'd4
    } state_e;

    // Bits needed to index n distinct values; at least one bit.
    function automatic int cnt_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/c432_key_ctrl_if.sv
// -----------------------------------------------------------------------------
// c432_key_ctrl_if
// Key-load handshake bundle between a key source (master) and the controller
// (slave).
//   start   : master -> slave, request a new key load
//   key_bit : master -> slave, serial key data, LSB first
//   key_vld : master -> slave, key_bit valid
//   key_rdy : slave -> master, controller accepts key_bit
// -----------------------------------------------------------------------------
interface c432_key_ctrl_if;

    logic start;
    logic key_bit;
    logic key_vld;
    logic key_rdy;

    modport master (
        output start,
        output key_bit,
        output key_vld,
        input  key_rdy
    );

    modport slave (
        input  start,
        input  key_bit,
        input  key_vld,
        output key_rdy
    );

endinterface

// File: rtl/c432_key_ctrl_key_sipo.sv
// -----------------------------------------------------------------------------
// key_sipo
// Serial-in/parallel-out key assembler with bit counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear of shift register and bit counter
//   shift_en  : accepted handshake this cycle; key_bit is stored at bitcnt
//   bit_in    : serial key bit
//   key_nxt   : shift register including this cycle's bit (combinational),
//               so the caller can commit the full key on the final edge
//   done      : final-bit handshake strobe (combinational)
// -----------------------------------------------------------------------------
module key_sipo
    import c432_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [KEY_W-1:0] key_nxt,
    output logic             done
);

    localparam int CNT_W = cnt_w(KEY_W);
    localparam logic [CNT_W-1:0] LAST_IDX = (CNT_W)'(KEY_W - 1);

    logic [KEY_W-1:0] shreg_r;
    logic [CNT_W-1:0] bitcnt_r;

    // Insert the incoming bit at the current index without disturbing others.
    always_comb begin
        key_nxt          = shreg_r;
        key_nxt[bitcnt_r] = bit_in;
    end

    assign done = shift_en && (bitcnt_r == LAST_IDX);

    // Shift register and bit counter; counter returns to zero after the last bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            shreg_r  <= {KEY_W{1'b0}};
            bitcnt_r <= {CNT_W{1'b0}};
        end else if (shift_en) begin
            shreg_r  <= key_nxt;
            bitcnt_r <= done ? {CNT_W{1'b0}} : bitcnt_r + (CNT_W)'(1);
        end else begin
            shreg_r  <= shreg_r;
            bitcnt_r <= bitcnt_r;
        end
    end

endmodule

// File: rtl/c432_key_ctrl.sv
// -----------------------------------------------------------------------------
// c432_key_ctrl
// Loads a serial key into the p-inputs of a logic-locked c432 core, waits for
// the core to settle, then registers the core outputs with a valid flag.
//   clk, rst  : clock, synchronous active-high reset
//   kif       : key-load handshake (start, key_bit, key_vld, key_rdy)
//   key_out   : key applied to core p-inputs, bit0 = p1; updated atomically
//   core_in   : core outputs {N223,N329,N370,N421,N430,N431,N432}
//   core_out  : registered core outputs (1-cycle latency in RUN)
//   out_vld   : core_out valid under the committed key
//   locked    : lockout active
// Build option: define C432_KEY_LOCKOUT_EN to limit the number of key commits
// to MAX_TRIES; a further start then enters LOCKED until reset. Without it,
// commits are unlimited and locked is constant 0.
// -----------------------------------------------------------------------------
module c432_key_ctrl
    import c432_key_pkg::*;
#(
    parameter int KEY_W      = KEY_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int MAX_TRIES  = MAX_TRIES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    c432_key_ctrl_if.slave        kif,
    output logic [KEY_W-1:0]      key_out,
    input  logic [CORE_OUT_W-1:0] core_in,
    output logic [CORE_OUT_W-1:0] core_out,
    output logic                  out_vld,
    output logic                  locked
);

    if (KEY_W < 1 || SETTLE_CYC < 1 || MAX_TRIES < 1) begin : g_param_chk
        $error("c432_key_ctrl: KEY_W, SETTLE_CYC and MAX_TRIES must be >= 1");
    end

    localparam int SCNT_W = cnt_w(SETTLE_CYC);
    localparam logic [SCNT_W-1:0] SETTLE_LAST = (SCNT_W)'(SETTLE_CYC - 1);

    state_e              state_r;
    state_e              state_nxt_s;
    logic                rdy_s;
    logic                hs_s;
    logic                done_s;
    logic                sipo_clr_s;
    logic                settle_done_s;
    logic                lock_hit_s;
    logic [KEY_W-1:0]    key_nxt_s;
    logic [SCNT_W-1:0]   settle_cnt_r;
    logic [KEY_W-1:0]    key_out_r;
    logic [CORE_OUT_W-1:0] core_out_r;
    logic                out_vld_r;

    assign rdy_s       = (state_r == ST_SHIFT);
    assign hs_s        = kif.key_vld && rdy_s;
    assign kif.key_rdy = rdy_s;

    key_sipo #(
        .KEY_W (KEY_W)
    ) u_sipo (
        .clk      (clk),
        .rst      (rst),
        .clr      (sipo_clr_s),
        .shift_en (hs_s),
        .bit_in   (kif.key_bit),
        .key_nxt  (key_nxt_s),
        .done     (done_s)
    );

    assign settle_done_s = (state_r == ST_SETTLE) && (settle_cnt_r == SETTLE_LAST);

`ifdef C432_KEY_LOCKOUT_EN
    localparam int TRY_W = cnt_w(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] TRY_MAX = (TRY_W)'(MAX_TRIES);

    logic [TRY_W-1:0] tries_r;
    logic             locked_r;

    assign lock_hit_s = (tries_r == TRY_MAX);

    // Saturating count of committed keys.
    always_ff @(posedge clk) begin
        if (rst) begin
            tries_r <= {TRY_W{1'b0}};
        end else if (done_s && (tries_r != TRY_MAX)) begin
            tries_r <= tries_r + (TRY_W)'(1);
        end else begin
            tries_r <= tries_r;
        end
    end

    // Lockout flag follows the state being entered so it aligns with key_out clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_r <= 1'b0;
        end else begin
            locked_r <= (state_nxt_s == ST_LOCKED);
        end
    end

    assign locked = locked_r;
`else
    assign lock_hit_s = 1'b0;
    assign locked     = 1'b0;
`endif

    // Next-state logic; start is only honoured in IDLE and RUN.
    always_comb begin
        state_nxt_s = state_r;
        sipo_clr_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (kif.start) begin
                    if (lock_hit_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                        sipo_clr_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (done_s) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_SETTLE: begin
                if (settle_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (kif.start) begin
                    if (lock_hit_s) begin
                        state_nxt_s = ST_LOCKED;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                        sipo_clr_s  = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOCKED: begin
                state_nxt_s = ST_LOCKED;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Settle counter: restarts on commit, advances only while settling.
    always_ff @(posedge clk) begin
        if (rst || done_s) begin
            settle_cnt_r <= {SCNT_W{1'b0}};
        end else if (state_r == ST_SETTLE) begin
            settle_cnt_r <= settle_cnt_r + (SCNT_W)'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Key register: changes only on a full commit (never a partial key) or lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_out_r <= {KEY_W{1'b0}};
        end else if (state_nxt_s == ST_LOCKED) begin
            key_out_r <= {KEY_W{1'b0}};
        end else if (done_s) begin
            key_out_r <= key_nxt_s;
        end else begin
            key_out_r <= key_out_r;
        end
    end

    // Core output capture in RUN; a restart cycle keeps the last sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_out_r <= {CORE_OUT_W{1'b0}};
        end else if ((state_r == ST_RUN) && !kif.start) begin
            core_out_r <= core_in;
        end else begin
            core_out_r <= core_out_r;
        end
    end

    // Valid rises after the first RUN cycle and drops on the cycle after a restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_r <= 1'b0;
        end else begin
            out_vld_r <= (state_r == ST_RUN) && !kif.start;
        end
    end

    assign key_out  = key_out_r;
    assign core_out = core_out_r;
    assign out_vld  = out_vld_r;

endmodule
